// File: rtl/vector_vl_sequencer.sv
// ---------------------------------------------------------------------------
// vector_vl_sequencer
//
// Beat sequencer that sits directly after the vector control register file.
// When an instruction is issued it captures the live vector length, clamps
// it to VLMAX, and then walks the vector NUMLANES elements at a time,
// presenting one lane-enable mask per beat. Downstream may stall a beat, and
// flush aborts the instruction in flight. A one-cycle done pulse marks
// completion, including for zero-length instructions.
//
// Ports:
//   clk          in   clock
//   resetn       in   synchronous active-low reset
//   vl           in   [VLWIDTH]   vector length (control register 0)
//   start        in   issue request, accepted when start && start_ready
//   start_ready  out  high while idle
//   flush        in   synchronous abort of the current instruction
//   stall        in   downstream cannot take the current beat
//   beat_valid   out  current beat outputs are valid
//   beat_mask    out  [NUMLANES]  lane enables, bit i = lane i
//   beat_base    out  [VLWIDTH]   element index of lane 0 in this beat
//   beat_last    out  current beat is the final one
//   busy         out  sequencing an instruction
//   done         out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module vector_vl_sequencer #(
  parameter int NUMLANES     = 8,
  parameter int LOG2NUMLANES = 3,
  parameter int VLMAX        = 64,
  parameter int VLWIDTH      = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [VLWIDTH-1:0]  vl,
  input  logic                start,
  output logic                start_ready,
  input  logic                flush,
  input  logic                stall,
  output logic                beat_valid,
  output logic [NUMLANES-1:0] beat_mask,
  output logic [VLWIDTH-1:0]  beat_base,
  output logic                beat_last,
  output logic                busy,
  output logic                done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [VLWIDTH-1:0] VLMAX_W = VLWIDTH'(VLMAX);
  localparam logic [VLWIDTH-1:0] STEP_W  = VLWIDTH'(1) << LOG2NUMLANES;
  localparam logic [VLWIDTH-1:0] LANES_W = VLWIDTH'(NUMLANES);

  state_t               r_state, w_state_nxt;
  logic [VLWIDTH-1:0]   r_len, w_len_nxt;
  logic [VLWIDTH-1:0]   r_base, w_base_nxt;
  logic                 r_done, w_done_nxt;

  logic [VLWIDTH-1:0]   w_vl_clamped;
  logic [VLWIDTH-1:0]   w_rem;
  logic                 w_run;

  // Unsigned full-width compare, so any vl at or above VLMAX clamps to VLMAX.
  assign w_vl_clamped = (vl > VLMAX_W) ? VLMAX_W : vl;

  assign w_run       = (r_state == ST_RUN);
  // Remaining elements; nonzero whenever in RUN.
  assign w_rem       = r_len - r_base;

  assign start_ready = (r_state == ST_IDLE);
  assign busy        = w_run;
  assign done        = r_done;
  assign beat_valid  = w_run;
  assign beat_last   = w_run && (w_rem <= LANES_W);
  assign beat_base   = w_run ? r_base : '0;

  always_comb begin
    for (int i = 0; i < NUMLANES; i++) begin
      beat_mask[i] = w_run && (VLWIDTH'(i) < w_rem);
    end
  end

  // Next-state logic. Stall needs no explicit hold path: the beat outputs
  // are pure functions of r_base/r_len, which only move on consumption.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_base_nxt  = r_base;
    w_done_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // flush in IDLE drops a simultaneous start.
        if (start && !flush) begin
          w_len_nxt  = w_vl_clamped;
          w_base_nxt = '0;
          if (w_vl_clamped == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // flush outranks both stall and consumption, and suppresses done.
        if (flush) begin
          w_state_nxt = ST_IDLE;
        end else if (!stall) begin
          if (beat_last) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_base_nxt = r_base + STEP_W;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples the same pre-edge values regardless of statement order.
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_base  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_base  <= w_base_nxt;
      r_done  <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_vector_vl_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vector_vl_sequencer
//
// Directed bench for vector_vl_sequencer (NUMLANES=8, VLMAX=64, VLWIDTH=32).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_vector_vl_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] vl;
  logic        start;
  logic        start_ready;
  logic        flush;
  logic        stall;
  logic        beat_valid;
  logic [7:0]  beat_mask;
  logic [31:0] beat_base;
  logic        beat_last;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  vector_vl_sequencer #(
    .NUMLANES(8), .LOG2NUMLANES(3), .VLMAX(64), .VLWIDTH(32)
  ) dut (
    .clk(clk), .resetn(resetn), .vl(vl), .start(start),
    .start_ready(start_ready), .flush(flush), .stall(stall),
    .beat_valid(beat_valid), .beat_mask(beat_mask), .beat_base(beat_base),
    .beat_last(beat_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected beat presented this cycle.
  task automatic check_beat(input string tag, input logic [31:0] base,
                            input logic [7:0] mask, input logic last);
    check({tag, ".valid"}, 32'(beat_valid), 32'd1);
    check({tag, ".base"},  beat_base,       base);
    check({tag, ".mask"},  32'(beat_mask),  32'(mask));
    check({tag, ".last"},  32'(beat_last),  32'(last));
    check({tag, ".busy"},  32'(busy),       32'd1);
    check({tag, ".done"},  32'(done),       32'd0);
  endtask

  // Idle with every beat output at its reset value.
  task automatic check_idle(input string tag, input logic exp_done);
    check({tag, ".valid"}, 32'(beat_valid),  32'd0);
    check({tag, ".mask"},  32'(beat_mask),   32'd0);
    check({tag, ".base"},  beat_base,        32'd0);
    check({tag, ".last"},  32'(beat_last),   32'd0);
    check({tag, ".busy"},  32'(busy),        32'd0);
    check({tag, ".rdy"},   32'(start_ready), 32'd1);
    check({tag, ".done"},  32'(done),        32'(exp_done));
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; flush = 1'b0; stall = 1'b0; vl = '0;
    tick(); tick();
    check_idle("reset", 1'b0);
    resetn = 1'b1;
    tick();

    // Basic run, vl=20: 8+8+4.
    vl = 32'd20; start = 1'b1;
    tick(); start = 1'b0;
    check("basic.rdy", 32'(start_ready), 32'd0);
    check_beat("basic.b0", 32'd0,  8'hFF, 1'b0); tick();
    check_beat("basic.b1", 32'd8,  8'hFF, 1'b0); tick();
    check_beat("basic.b2", 32'd16, 8'h0F, 1'b1); tick();
    check_idle("basic.end", 1'b1); tick();
    check("basic.done_pulse", 32'(done), 32'd0);

    // Clamp: vl=0xFFFFFFFF sequences exactly 64 elements.
    vl = 32'hFFFF_FFFF; start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_beat($sformatf("clamp.b%0d", k), 32'(k * 8), 8'hFF, (k == 7));
      tick();
    end
    check_idle("clamp.end", 1'b1); tick();

    // Exact multiple: vl=8 -> one full last beat.
    vl = 32'd8; start = 1'b1;
    tick(); start = 1'b0;
    check_beat("vl8.b0", 32'd0, 8'hFF, 1'b1); tick();
    check_idle("vl8.end", 1'b1); tick();

    // Zero length: done at T+1, no beats, never busy.
    vl = 32'd0; start = 1'b1;
    tick(); start = 1'b0;
    check_idle("vl0.end", 1'b1); tick();
    check_idle("vl0.after", 1'b0);

    // Stall for 3 edges on beat 0 of vl=12.
    vl = 32'd12; start = 1'b1;
    tick(); start = 1'b0; stall = 1'b1;
    check_beat("stall.b0", 32'd0, 8'hFF, 1'b0); tick();
    check_beat("stall.h1", 32'd0, 8'hFF, 1'b0); tick();
    check_beat("stall.h2", 32'd0, 8'hFF, 1'b0); tick();
    stall = 1'b0;
    check_beat("stall.h3", 32'd0, 8'hFF, 1'b0); tick();
    check_beat("stall.b1", 32'd8, 8'h0F, 1'b1); tick();
    check_idle("stall.end", 1'b1); tick();

    // Flush during beat 1 of vl=24; vl rewritten to 4 mid-run is ignored.
    vl = 32'd24; start = 1'b1;
    tick(); start = 1'b0; vl = 32'd4;
    check_beat("flush.b0", 32'd0, 8'hFF, 1'b0); tick();
    check_beat("flush.b1", 32'd8, 8'hFF, 1'b0);
    flush = 1'b1;
    tick(); flush = 1'b0;
    check_idle("flush.idle", 1'b0); tick();
    check_idle("flush.nodone", 1'b0);

    // Flush in IDLE drops a simultaneous start.
    vl = 32'd8; start = 1'b1; flush = 1'b1;
    tick(); start = 1'b0; flush = 1'b0;
    check_idle("flush_idle", 1'b0); tick();
    check_idle("flush_idle.after", 1'b0);

    // Reset asserted mid-run.
    vl = 32'd20; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    check_beat("rst.b1", 32'd8, 8'hFF, 1'b0);
    resetn = 1'b0;
    tick(); resetn = 1'b1;
    check_idle("rst.mid", 1'b0); tick();
    check_idle("rst.after", 1'b0);

    // Back-to-back: second start accepted in the done cycle.
    vl = 32'd8; start = 1'b1;
    tick(); start = 1'b0;
    check_beat("b2b.first", 32'd0, 8'hFF, 1'b1); tick();
    check_idle("b2b.done", 1'b1);
    vl = 32'd16; start = 1'b1;
    tick(); start = 1'b0;
    check_beat("b2b.b0", 32'd0, 8'hFF, 1'b0); tick();
    check_beat("b2b.b1", 32'd8, 8'hFF, 1'b1); tick();
    check_idle("b2b.end", 1'b1); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
